lsu_bus_wb_buf: RTL and testbench
=================================

# lsu_bus_wb_buf

Buffers uncached/MMIO bus responses for the LSU and presents them, one per cycle, to the LSU writeback arbiter's bus port. Load data is extracted and sign/zero-extended at enqueue, so the arbiter receives PRF-ready data. The block sits between the LSU bus interface unit and the writeback arbiter. It decouples bus response timing from the arbiter's priority-based `wb_arb_bus_rdy` back-pressure.

## Interface
- `XLEN`, 64, data width
- `ROB_INDEX_WIDTH`, 6, ROB index width
- `PHY_REG_ADDR_WIDTH`, 6, physical register address width
- `DEPTH`, 4, number of buffer entries; power of two, ≥2

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high, on `clk`
- `flush`  in  1  pipeline flush; discards all buffered and incoming responses
- `bus_resp_vld_i`  in  1  bus response valid
- `bus_resp_rdy_o`  out  1  buffer can accept a response
- `bus_resp_rob_index_i`  in  ROB_INDEX_WIDTH  ROB index of the completing op
- `bus_resp_is_load_i`  in  1  1 = load (writes the PRF); 0 = store (ROB completion only)
- `bus_resp_rd_addr_i`  in  PHY_REG_ADDR_WIDTH  destination physical register
- `bus_resp_opcode_i`  in  3  load size/sign: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU
- `bus_resp_offset_i`  in  3  byte offset of the access within the 8-byte beat
- `bus_resp_data_i`  in  XLEN  raw 8-byte-aligned bus data
- `bus_wb_arb_wb_vld_o`  out  1  ROB writeback valid
- `bus_wb_arb_wb_rob_index_o`  out  ROB_INDEX_WIDTH  head ROB index
- `bus_wb_arb_prf_wb_vld_o`  out  1  PRF writeback valid
- `bus_wb_arb_prf_wb_rd_addr_o`  out  PHY_REG_ADDR_WIDTH  head rd
- `bus_wb_arb_prf_wb_data_o`  out  XLEN  head extracted data
- `wb_arb_bus_rdy_i`  in  1  arbiter accepts the head this cycle
- `bus_wb_cnt_o`  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Circular buffer with head/tail pointers ($clog2(DEPTH) bits, natural wrap) and an occupancy counter.
- Enqueue when `bus_resp_vld_i & bus_resp_rdy_o & ~flush`.
  - Stored fields: rob index, is_load, rd, extracted data.
- Extraction:
  - Shift amount = `bus_resp_data_i >> (offset*8)`.
  - Truncate to 8/16/32/64 bits by `opcode[1:0]`.
  - `opcode[2]=0` sign-extends; `opcode[2]=1` zero-extends.
  - Opcode 111 stores data 0.
  - Stores store data 0.
- Output drive:
  - `bus_wb_arb_wb_vld_o = (cnt!=0)`.
  - `bus_wb_arb_prf_wb_vld_o = wb_vld_o & head.is_load`.
  - Index, rd and data outputs are 0 whenever `wb_vld_o=0`.
- Dequeue when `bus_wb_arb_wb_vld_o & wb_arb_bus_rdy_i`; the head pointer advances.
- `bus_resp_rdy_o = ~rst & (cnt < DEPTH)`. This uses registered occupancy only: a same-cycle dequeue does not free a slot for a same-cycle enqueue.
- Simultaneous enqueue and dequeue: cnt unchanged, both pointers advance.
- Flush:
  - Next cycle cnt=0 and head=tail=0.
  - A response handshaken in the flush cycle is dropped.
  - The arbiter's acceptance in the flush cycle is harmless.
  - Flush during reset has no additional effect.
- No combinational path from `wb_arb_bus_rdy_i` to any `*_vld_o`.

## Timing
- Reset:
  - Applied on the next `clk` edge while `rst=1`: cnt=0, pointers=0.
  - All outputs are 0 during and after reset until an enqueue, except `bus_resp_rdy_o`, which is 0 while `rst=1` and 1 afterwards.
- Latency, base build: a response accepted at edge N is visible on the outputs from cycle N+1.
- Throughput: 1 enqueue and 1 dequeue per cycle.
- The head is held stable while `wb_vld_o=1` and `wb_arb_bus_rdy_i=0`.

## Configuration
- `LSU_BUS_WB_BYPASS_EN` defined:
  - When cnt==0 and `bus_resp_vld_i=1`, outputs are driven combinationally from the incoming response (extracted data), so `wb_vld_o=1` in the same cycle.
  - If `wb_arb_bus_rdy_i=1` that cycle, the response is consumed and not enqueued: 0-cycle latency.
  - Otherwise it is enqueued normally.
  - With `flush=1`, bypass is suppressed: valid outputs 0.
- Not defined: no bypass; minimum latency 1 cycle.

## Structure
- Shared package / params header holds:
  - load opcode encodings (LB…LWU) as named constants;
  - a `lsu_bus_wb_entry` field layout {rob_index, is_load, rd, data}.
  - XLEN, ROB_INDEX_WIDTH and PHY_REG_ADDR_WIDTH come from the common params.
- One sub-module, `lsu_load_data_align`: purely combinational offset shift plus size/sign extension. It is reusable by the L1D load path.

## Test plan
- Reset then single LB, offset 3, data 0x0000_0000_8000_0000 (byte3=0x80), rdy held 1 -> cycle N+1: prf_vld=1, data 0xFFFF_FFFF_FFFF_FF80; cycle N+2: vld=0, cnt=0.
- LHU offset 6, data 0xBEEF_0000_0000_0000 -> data 0x0000_0000_0000_BEEF. Store response (is_load=0, rob 5) -> wb_vld=1, rob_index=5, prf_vld=0.
- rdy=0 and 4 responses (rob 1..4) -> cnt=4, `bus_resp_rdy_o=0`, 5th response held. Then rdy=1 -> rob 1,2,3,4 delivered in order on consecutive cycles, pointers wrap cleanly.
- Full buffer, enqueue and dequeue offered in the same cycle -> enqueue refused (rdy_o=0), cnt 4→3.
- cnt=3 plus a response arriving with `flush=1` -> next cycle cnt=0, all valids 0. A response two cycles later is delivered normally.
- `LSU_BUS_WB_BYPASS_EN`, empty buffer, LD data 0x1234_5678_9ABC_DEF0, rdy=1 -> same-cycle wb_vld=1 with that data, cnt stays 0. With rdy=0 -> cnt=1 next cycle.

Source files
------------

// File: rtl/lsu_bus_wb_buf_pkg.sv
// Shared types and constants for the LSU bus writeback buffer and load alignment.
package lsu_bus_wb_buf_pkg;

   localparam int unsigned XLEN               = 64;
   localparam int unsigned ROB_INDEX_WIDTH    = 6;
   localparam int unsigned PHY_REG_ADDR_WIDTH = 6;

   localparam logic [2:0] LD_OP_LB  = 3'b000;
   localparam logic [2:0] LD_OP_LH  = 3'b001;
   localparam logic [2:0] LD_OP_LW  = 3'b010;
   localparam logic [2:0] LD_OP_LD  = 3'b011;
   localparam logic [2:0] LD_OP_LBU = 3'b100;
   localparam logic [2:0] LD_OP_LHU = 3'b101;
   localparam logic [2:0] LD_OP_LWU = 3'b110;

   typedef struct packed {
      logic [ROB_INDEX_WIDTH-1:0]    rob_index;
      logic                          is_load;
      logic [PHY_REG_ADDR_WIDTH-1:0] rd;
      logic [XLEN-1:0]               data;
   } lsu_bus_wb_entry_t;

endpackage

// File: rtl/lsu_load_data_align.sv
// Combinational load data alignment: byte-offset shift then size truncation with sign/zero extension.
module lsu_load_data_align
   import lsu_bus_wb_buf_pkg::*;
(
   input  logic [XLEN-1:0] data_i,
   input  logic [2:0]      offset_i,
   input  logic [2:0]      opcode_i,
   output logic [XLEN-1:0] data_c
);

   logic [XLEN-1:0] shifted;

   always_comb begin
      shifted = data_i >> {offset_i, 3'b000};
      data_c  = '0;
      case (opcode_i)
         LD_OP_LB:  data_c = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         LD_OP_LH:  data_c = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         LD_OP_LW:  data_c = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
         LD_OP_LD:  data_c = shifted;
         LD_OP_LBU: data_c = {{(XLEN-8){1'b0}}, shifted[7:0]};
         LD_OP_LHU: data_c = {{(XLEN-16){1'b0}}, shifted[15:0]};
         LD_OP_LWU: data_c = {{(XLEN-32){1'b0}}, shifted[31:0]};
         default:   data_c = '0;
      endcase
   end

endmodule

// File: rtl/lsu_bus_wb_buf.sv
// Buffers uncached/MMIO bus responses and presents them one per cycle to the writeback arbiter.
// Optional same-cycle bypass when empty: define LSU_BUS_WB_BYPASS_EN.
module lsu_bus_wb_buf
   import lsu_bus_wb_buf_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          bus_resp_vld_i,
   output logic                          bus_resp_rdy_o,
   input  logic [ROB_INDEX_WIDTH-1:0]    bus_resp_rob_index_i,
   input  logic                          bus_resp_is_load_i,
   input  logic [PHY_REG_ADDR_WIDTH-1:0] bus_resp_rd_addr_i,
   input  logic [2:0]                    bus_resp_opcode_i,
   input  logic [2:0]                    bus_resp_offset_i,
   input  logic [XLEN-1:0]               bus_resp_data_i,
   output logic                          bus_wb_arb_wb_vld_o,
   output logic [ROB_INDEX_WIDTH-1:0]    bus_wb_arb_wb_rob_index_o,
   output logic                          bus_wb_arb_prf_wb_vld_o,
   output logic [PHY_REG_ADDR_WIDTH-1:0] bus_wb_arb_prf_wb_rd_addr_o,
   output logic [XLEN-1:0]               bus_wb_arb_prf_wb_data_o,
   input  logic                          wb_arb_bus_rdy_i,
   output logic [$clog2(DEPTH):0]        bus_wb_cnt_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   lsu_bus_wb_entry_t mem_q [DEPTH];
   lsu_bus_wb_entry_t mem_d [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [XLEN-1:0]   align_data_c;
   lsu_bus_wb_entry_t in_entry_c, out_entry_c;
   logic              not_empty_c, byp_c, enq_c, deq_c, out_vld_c;

   lsu_load_data_align u_align (
      .data_i   (bus_resp_data_i),
      .offset_i (bus_resp_offset_i),
      .opcode_i (bus_resp_opcode_i),
      .data_c   (align_data_c)
   );

   // Handshake qualification; registered occupancy only, so a dequeue never frees a slot same-cycle
   always_comb begin
      in_entry_c.rob_index = bus_resp_rob_index_i;
      in_entry_c.is_load   = bus_resp_is_load_i;
      in_entry_c.rd        = bus_resp_rd_addr_i;
      in_entry_c.data      = bus_resp_is_load_i ? align_data_c : '0;
      not_empty_c          = (cnt_q != '0);
      bus_resp_rdy_o       = ~rst & (cnt_q < CNT_W'(DEPTH));
`ifdef LSU_BUS_WB_BYPASS_EN
      byp_c = ~not_empty_c & bus_resp_vld_i & ~flush & ~rst;
`else
      byp_c = 1'b0;
`endif
      enq_c = bus_resp_vld_i & bus_resp_rdy_o & ~flush & ~(byp_c & wb_arb_bus_rdy_i);
      deq_c = not_empty_c & wb_arb_bus_rdy_i;
   end

   always_comb begin
      mem_d  = mem_q;
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q + CNT_W'(enq_c) - CNT_W'(deq_c);
      if (enq_c) begin
         mem_d[tail_q] = in_entry_c;
         tail_d        = tail_q + PTR_W'(1);
      end
      if (deq_c) head_d = head_q + PTR_W'(1);
      if (flush) begin
         head_d = '0;
         tail_d = '0;
         cnt_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   // Payload storage needs no reset: it is only observed behind a valid count
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
      out_entry_c                 = not_empty_c ? mem_q[head_q] : in_entry_c;
      out_vld_c                   = not_empty_c | byp_c;
      bus_wb_arb_wb_vld_o         = out_vld_c;
      bus_wb_arb_prf_wb_vld_o     = out_vld_c & out_entry_c.is_load;
      bus_wb_arb_wb_rob_index_o   = out_vld_c ? out_entry_c.rob_index : '0;
      bus_wb_arb_prf_wb_rd_addr_o = out_vld_c ? out_entry_c.rd : '0;
      bus_wb_arb_prf_wb_data_o    = out_vld_c ? out_entry_c.data : '0;
      bus_wb_cnt_o                = cnt_q;
   end

endmodule

// File: tb/tb_lsu_bus_wb_buf.sv
// Self-checking bench for lsu_bus_wb_buf: directed scenarios plus a randomized queue-model comparison.
module tb_lsu_bus_wb_buf;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, flush;
   logic        bus_resp_vld_i, bus_resp_rdy_o;
   logic [5:0]  bus_resp_rob_index_i;
   logic        bus_resp_is_load_i;
   logic [5:0]  bus_resp_rd_addr_i;
   logic [2:0]  bus_resp_opcode_i, bus_resp_offset_i;
   logic [63:0] bus_resp_data_i;
   logic        wb_vld, prf_vld;
   logic [5:0]  wb_rob, prf_rd;
   logic [63:0] prf_data;
   logic        wb_arb_bus_rdy_i;
   logic [2:0]  cnt;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [5:0]  rob;
      logic        ld;
      logic [5:0]  rd;
      logic [63:0] data;
   } model_t;

   lsu_bus_wb_buf #(.DEPTH(DEPTH)) dut (
      .clk                         (clk),
      .rst                         (rst),
      .flush                       (flush),
      .bus_resp_vld_i              (bus_resp_vld_i),
      .bus_resp_rdy_o              (bus_resp_rdy_o),
      .bus_resp_rob_index_i        (bus_resp_rob_index_i),
      .bus_resp_is_load_i          (bus_resp_is_load_i),
      .bus_resp_rd_addr_i          (bus_resp_rd_addr_i),
      .bus_resp_opcode_i           (bus_resp_opcode_i),
      .bus_resp_offset_i           (bus_resp_offset_i),
      .bus_resp_data_i             (bus_resp_data_i),
      .bus_wb_arb_wb_vld_o         (wb_vld),
      .bus_wb_arb_wb_rob_index_o   (wb_rob),
      .bus_wb_arb_prf_wb_vld_o     (prf_vld),
      .bus_wb_arb_prf_wb_rd_addr_o (prf_rd),
      .bus_wb_arb_prf_wb_data_o    (prf_data),
      .wb_arb_bus_rdy_i            (wb_arb_bus_rdy_i),
      .bus_wb_cnt_o                (cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [5:0] rob, input logic ld, input logic [5:0] rd,
                        input logic [2:0] opc, input logic [2:0] off, input logic [63:0] d);
      bus_resp_vld_i       = v;
      bus_resp_rob_index_i = rob;
      bus_resp_is_load_i   = ld;
      bus_resp_rd_addr_i   = rd;
      bus_resp_opcode_i    = opc;
      bus_resp_offset_i    = off;
      bus_resp_data_i      = d;
   endtask

   // Reference extraction from the load semantics: pick the addressed bytes, then extend
   function automatic logic [63:0] ref_extract(input logic [63:0] d, input int off, input int opc,
                                               input logic ld);
      logic [63:0] s;
      longint      r;
      s = d >> (off * 8);
      case (opc)
         0: r = longint'($signed(s[7:0]));
         1: r = longint'($signed(s[15:0]));
         2: r = longint'($signed(s[31:0]));
         3: r = longint'(s);
         4: r = longint'({56'd0, s[7:0]});
         5: r = longint'({48'd0, s[15:0]});
         6: r = longint'({32'd0, s[31:0]});
         default: r = 0;
      endcase
      if (!ld) r = 0;
      return 64'(r);
   endfunction

   task automatic test_reset();
      rst = 1'b1; flush = 1'b1; wb_arb_bus_rdy_i = 1'b0;
      drive(1'b1, 6'd3, 1'b1, 6'd3, 3'd3, 3'd0, 64'h1111);
      tick(); tick();
      n_vec++; if (bus_resp_rdy_o !== 1'b0) begin n_err++; $display("FAIL reset_rdy: got %b expected 0", bus_resp_rdy_o); end
      n_vec++; if (wb_vld !== 1'b0 || prf_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b/%b expected 0/0", wb_vld, prf_vld); end
      n_vec++; if (cnt !== 3'd0) begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
      drive(1'b0, '0, 1'b0, '0, '0, '0, '0);
      flush = 1'b0; rst = 1'b0;
      #1;
      n_vec++; if (bus_resp_rdy_o !== 1'b1) begin n_err++; $display("FAIL post_reset_rdy: got %b expected 1", bus_resp_rdy_o); end
      n_vec++; if (wb_vld !== 1'b0 || wb_rob !== 6'd0 || prf_data !== 64'd0) begin n_err++; $display("FAIL post_reset_out: got vld %b rob %h data %h expected 0", wb_vld, wb_rob, prf_data); end
      tick();
   endtask

   task automatic test_single();
      wb_arb_bus_rdy_i = 1'b1;
      drive(1'b1, 6'd9, 1'b1, 6'd7, 3'b000, 3'd3, 64'h0000_0000_8000_0000);
      tick();
      drive(1'b0, '0, 1'b0, '0, '0, '0, '0);
      n_vec++; if (wb_vld !== 1'b1 || prf_vld !== 1'b1) begin n_err++; $display("FAIL lb_vld: got %b/%b expected 1/1", wb_vld, prf_vld); end
      n_vec++; if (prf_data !== 64'hFFFF_FFFF_FFFF_FF80) begin n_err++; $display("FAIL lb_data: got %h expected ffffffffffffff80", prf_data); end
      n_vec++; if (wb_rob !== 6'd9 || prf_rd !== 6'd7) begin n_err++; $display("FAIL lb_tags: got rob %0d rd %0d expected 9 7", wb_rob, prf_rd); end
      tick();
      n_vec++; if (wb_vld !== 1'b0 || cnt !== 3'd0) begin n_err++; $display("FAIL lb_drain: got vld %b cnt %0d expected 0 0", wb_vld, cnt); end
      drive(1'b1, 6'd10, 1'b1, 6'd2, 3'b101, 3'd6, 64'hBEEF_0000_0000_0000);
      tick();
      drive(1'b1, 6'd5, 1'b0, 6'd4, 3'b011, 3'd0, 64'hDEAD_BEEF_DEAD_BEEF);
      n_vec++; if (prf_data !== 64'h0000_0000_0000_BEEF || prf_vld !== 1'b1) begin n_err++; $display("FAIL lhu_data: got %h vld %b expected 000000000000beef 1", prf_data, prf_vld); end
      tick();
      drive(1'b0, '0, 1'b0, '0, '0, '0, '0);
      n_vec++; if (wb_vld !== 1'b1 || wb_rob !== 6'd5 || prf_vld !== 1'b0 || prf_data !== 64'd0) begin n_err++; $display("FAIL store: got vld %b rob %0d prf %b data %h expected 1 5 0 0", wb_vld, wb_rob, prf_vld, prf_data); end
      tick();
   endtask

   task automatic test_full();
      wb_arb_bus_rdy_i = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 6'(i), 1'b1, 6'(i + 32), 3'b011, 3'd0, 64'(i * 1000));
         tick();
      end
      drive(1'b1, 6'd15, 1'b1, 6'd47, 3'b011, 3'd0, 64'd15000);
      n_vec++; if (cnt !== 3'd4 || bus_resp_rdy_o !== 1'b0) begin n_err++; $display("FAIL full: got cnt %0d rdy %b expected 4 0", cnt, bus_resp_rdy_o); end
      tick();
      n_vec++; if (cnt !== 3'd4 || wb_rob !== 6'd1) begin n_err++; $display("FAIL full_hold: got cnt %0d rob %0d expected 4 1", cnt, wb_rob); end
      wb_arb_bus_rdy_i = 1'b1;
      #1;
      n_vec++; if (bus_resp_rdy_o !== 1'b0) begin n_err++; $display("FAIL full_enq_deq_rdy: got %b expected 0", bus_resp_rdy_o); end
      tick();
      n_vec++; if (cnt !== 3'd3 || wb_rob !== 6'd2) begin n_err++; $display("FAIL full_deq: got cnt %0d rob %0d expected 3 2", cnt, wb_rob); end
      tick();
      drive(1'b0, '0, 1'b0, '0, '0, '0, '0);
      n_vec++; if (cnt !== 3'd3 || wb_rob !== 6'd3) begin n_err++; $display("FAIL enq_deq: got cnt %0d rob %0d expected 3 3", cnt, wb_rob); end
      tick();
      n_vec++; if (wb_rob !== 6'd4 || prf_data !== 64'd4000) begin n_err++; $display("FAIL order4: got rob %0d data %0d expected 4 4000", wb_rob, prf_data); end
      tick();
      n_vec++; if (wb_rob !== 6'd15 || prf_rd !== 6'd47 || cnt !== 3'd1) begin n_err++; $display("FAIL order5: got rob %0d rd %0d cnt %0d expected 15 47 1", wb_rob, prf_rd, cnt); end
      tick();
      n_vec++; if (wb_vld !== 1'b0 || cnt !== 3'd0) begin n_err++; $display("FAIL full_drain: got vld %b cnt %0d expected 0 0", wb_vld, cnt); end
   endtask

   task automatic test_flush();
      wb_arb_bus_rdy_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 6'(20 + i), 1'b1, 6'd1, 3'b011, 3'd0, 64'(i));
         tick();
      end
      n_vec++; if (cnt !== 3'd3) begin n_err++; $display("FAIL pre_flush_cnt: got %0d expected 3", cnt); end
      drive(1'b1, 6'd23, 1'b1, 6'd1, 3'b011, 3'd0, 64'd99);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(1'b0, '0, 1'b0, '0, '0, '0, '0);
      n_vec++; if (cnt !== 3'd0 || wb_vld !== 1'b0 || prf_vld !== 1'b0 || wb_rob !== 6'd0) begin n_err++; $display("FAIL flush: got cnt %0d vld %b/%b rob %0d expected 0", cnt, wb_vld, prf_vld, wb_rob); end
      tick();
      wb_arb_bus_rdy_i = 1'b1;
      drive(1'b1, 6'd24, 1'b1, 6'd11, 3'b011, 3'd0, 64'hCAFE_F00D_1234_5678);
      tick();
      drive(1'b0, '0, 1'b0, '0, '0, '0, '0);
      n_vec++; if (wb_vld !== 1'b1 || wb_rob !== 6'd24 || prf_data !== 64'hCAFE_F00D_1234_5678) begin n_err++; $display("FAIL post_flush: got vld %b rob %0d data %h expected 1 24 cafef00d12345678", wb_vld, wb_rob, prf_data); end
      tick();
      n_vec++; if (cnt !== 3'd0 || wb_vld !== 1'b0) begin n_err++; $display("FAIL post_flush_drain: got cnt %0d vld %b expected 0 0", cnt, wb_vld); end
   endtask

`ifdef LSU_BUS_WB_BYPASS_EN
   task automatic test_bypass();
      wb_arb_bus_rdy_i = 1'b1;
      drive(1'b1, 6'd30, 1'b1, 6'd12, 3'b011, 3'd0, 64'h1234_5678_9ABC_DEF0);
      #1;
      n_vec++; if (wb_vld !== 1'b1 || prf_data !== 64'h1234_5678_9ABC_DEF0 || cnt !== 3'd0) begin n_err++; $display("FAIL bypass: got vld %b data %h cnt %0d expected 1 123456789abcdef0 0", wb_vld, prf_data, cnt); end
      tick();
      drive(1'b0, '0, 1'b0, '0, '0, '0, '0);
      n_vec++; if (cnt !== 3'd0 || wb_vld !== 1'b0) begin n_err++; $display("FAIL bypass_consumed: got cnt %0d vld %b expected 0 0", cnt, wb_vld); end
      wb_arb_bus_rdy_i = 1'b0;
      drive(1'b1, 6'd31, 1'b1, 6'd12, 3'b011, 3'd0, 64'h1234_5678_9ABC_DEF0);
      #1;
      n_vec++; if (wb_vld !== 1'b1 || wb_rob !== 6'd31) begin n_err++; $display("FAIL bypass_stall_vld: got vld %b rob %0d expected 1 31", wb_vld, wb_rob); end
      tick();
      drive(1'b0, '0, 1'b0, '0, '0, '0, '0);
      n_vec++; if (cnt !== 3'd1) begin n_err++; $display("FAIL bypass_enq: got cnt %0d expected 1", cnt); end
      wb_arb_bus_rdy_i = 1'b1;
      tick();
   endtask
`endif

   task automatic test_random();
      model_t q[$];
      model_t head;
      logic   byp, exp_vld, exp_rdy, accept, r_vld, r_rdy, r_flush;
      int     opc, off;
      for (int cyc = 0; cyc < 400; cyc++) begin
         r_vld   = ($urandom_range(0, 9) < 6);
         r_rdy   = ($urandom_range(0, 9) < 5);
         r_flush = ($urandom_range(0, 49) == 0);
         opc     = int'($urandom_range(0, 7));
         off     = int'($urandom_range(0, 7));
         drive(r_vld, 6'($urandom), 1'($urandom), 6'($urandom), 3'(opc), 3'(off),
               {$urandom, $urandom});
         wb_arb_bus_rdy_i = r_rdy;
         flush = r_flush;
         @(negedge clk);
`ifdef LSU_BUS_WB_BYPASS_EN
         byp = (q.size() == 0) && r_vld && !r_flush;
`else
         byp = 1'b0;
`endif
         if (q.size() != 0) head = q[0];
         else head = '{bus_resp_rob_index_i, bus_resp_is_load_i, bus_resp_rd_addr_i,
                       ref_extract(bus_resp_data_i, off, opc, bus_resp_is_load_i)};
         exp_vld = (q.size() != 0) || byp;
         exp_rdy = (q.size() < DEPTH);
         n_vec++; if (wb_vld !== exp_vld) begin n_err++; $display("FAIL rnd_vld cyc %0d: got %b expected %b", cyc, wb_vld, exp_vld); end
         n_vec++; if (prf_vld !== (exp_vld && head.ld)) begin n_err++; $display("FAIL rnd_prf_vld cyc %0d: got %b expected %b", cyc, prf_vld, exp_vld && head.ld); end
         n_vec++; if (wb_rob !== (exp_vld ? head.rob : 6'd0)) begin n_err++; $display("FAIL rnd_rob cyc %0d: got %0d expected %0d", cyc, wb_rob, exp_vld ? head.rob : 6'd0); end
         n_vec++; if (prf_rd !== (exp_vld ? head.rd : 6'd0)) begin n_err++; $display("FAIL rnd_rd cyc %0d: got %0d expected %0d", cyc, prf_rd, exp_vld ? head.rd : 6'd0); end
         n_vec++; if (prf_data !== (exp_vld ? head.data : 64'd0)) begin n_err++; $display("FAIL rnd_data cyc %0d: got %h expected %h", cyc, prf_data, exp_vld ? head.data : 64'd0); end
         n_vec++; if (bus_resp_rdy_o !== exp_rdy) begin n_err++; $display("FAIL rnd_rdy cyc %0d: got %b expected %b", cyc, bus_resp_rdy_o, exp_rdy); end
         n_vec++; if (cnt !== 3'(q.size())) begin n_err++; $display("FAIL rnd_cnt cyc %0d: got %0d expected %0d", cyc, cnt, q.size()); end
         accept = r_vld && exp_rdy && !r_flush;
         if (r_flush) q.delete();
         else begin
            if (q.size() != 0 && r_rdy) void'(q.pop_front());
            if (accept && !(byp && r_rdy))
               q.push_back('{bus_resp_rob_index_i, bus_resp_is_load_i, bus_resp_rd_addr_i,
                             ref_extract(bus_resp_data_i, off, opc, bus_resp_is_load_i)});
         end
         @(posedge clk);
         #1;
      end
      flush = 1'b0;
      drive(1'b0, '0, 1'b0, '0, '0, '0, '0);
   endtask

   initial begin
      test_reset();
`ifndef LSU_BUS_WB_BYPASS_EN
      test_single();
      test_full();
      test_flush();
`else
      test_bypass();
`endif
      flush = 1'b1;
      tick();
      flush = 1'b0;
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
